// File: rtl/booth_pkg.sv
// Shared types and sizing helpers for the radix-4 Booth multiplier.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package booth_pkg;

  // Controller states: waiting for a request, or retiring multiplier digits.
  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  // Radix-4 Booth digit selected from a 3-bit multiplier window.
  typedef enum logic [2:0] {
    ZERO = 3'd0,
    POS1 = 3'd1,
    POS2 = 3'd2,
    NEG1 = 3'd3,
    NEG2 = 3'd4
  } digit_t;

  // Iterations needed to consume a (W+2)-bit extended multiplier two bits at a time.
  function automatic int booth_iter(input int w);
    return w / 2 + 1;
  endfunction

  // Accumulator width: room for +/-2M on top of a (W+2)-bit extended operand.
  function automatic int booth_acc_w(input int w);
    return w + 4;
  endfunction

endpackage

// File: rtl/booth_r4_encoder.sv
// Combinational radix-4 Booth recoder: 3-bit window -> digit -> sign-extended addend.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows inputs.
module booth_r4_encoder
  import booth_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [2:0]   i_window,
  input  logic [W+1:0] i_m,
  output logic [W+3:0] o_addend
);

  digit_t       w_digit;
  logic [W+3:0] w_m1;
  logic [W+3:0] w_m2;

  // Sign-extended copies of M and 2M at accumulator width.
  always_comb begin
    w_m1 = {{2{i_m[W+1]}}, i_m};
    w_m2 = {i_m[W+1], i_m, 1'b0};
  end

  // Window {q[i+1], q[i], q[i-1]} to Booth digit.
  always_comb begin
    w_digit = ZERO;
    case (i_window)
      3'b000, 3'b111: w_digit = ZERO;
      3'b001, 3'b010: w_digit = POS1;
      3'b011:         w_digit = POS2;
      3'b100:         w_digit = NEG2;
      3'b101, 3'b110: w_digit = NEG1;
      default:        w_digit = ZERO;
    endcase
  end

  // Digit to two's-complement addend.
  always_comb begin
    o_addend = '0;
    case (w_digit)
      ZERO:    o_addend = '0;
      POS1:    o_addend = w_m1;
      POS2:    o_addend = w_m2;
      NEG1:    o_addend = -w_m1;
      NEG2:    o_addend = -w_m2;
      default: o_addend = '0;
    endcase
  end

endmodule

// File: rtl/booth_radix4_multiply.sv
// Sequential radix-4 Booth multiplier, signed/unsigned at runtime; optional MAC via BOOTH_MAC_EN.
// Latency: DONE pulses DATAWIDTH/2+1 cycles after the accepting START edge.
// Backpressure: START is ignored while BUSY; no queueing, one result per ITER+1 cycles.
module booth_radix4_multiply
  import booth_pkg::*;
#(
  parameter int DATAWIDTH = 32
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic                   i_signed_mode,
  input  logic [DATAWIDTH-1:0]   i_a,
  input  logic [DATAWIDTH-1:0]   i_b,
`ifdef BOOTH_MAC_EN
  input  logic                   i_accum,
`endif
  output logic [2*DATAWIDTH-1:0] o_result,
  output logic                   o_busy,
  output logic                   o_done
);

  localparam int W     = DATAWIDTH;
  localparam int ITER  = booth_iter(W);
  localparam int ACC_W = booth_acc_w(W);
  localparam int CNT_W = $clog2(ITER + 1);

  if (((DATAWIDTH % 2) != 0) || (DATAWIDTH < 4)) begin : g_bad_width
    $error("booth_radix4_multiply: DATAWIDTH must be even and >= 4");
  end

  state_t             r_state;
  state_t             w_state_nxt;
  logic [W+1:0]       r_m;
  logic [W+1:0]       r_q;
  logic               r_qm1;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*W-1:0]     r_result;
  logic               r_done;
`ifdef BOOTH_MAC_EN
  logic               r_accum;
`endif

  logic               w_last;
  logic [ACC_W-1:0]   w_addend;
  logic [ACC_W-1:0]   w_sum;
  logic [2*W+6:0]     w_shift;
  logic [ACC_W-1:0]   w_acc_nxt;
  logic [W+1:0]       w_q_nxt;
  logic               w_qm1_nxt;
  logic [2*W-1:0]     w_prod;
  logic [W+1:0]       w_a_ext;
  logic [W+1:0]       w_b_ext;

  booth_r4_encoder #(.W(W)) u_enc (
    .i_window (r_q[1:0] == 2'b00 ? {2'b00, r_qm1} : {r_q[1:0], r_qm1}),
    .i_m      (r_m),
    .o_addend (w_addend)
  );

  // Operand extension for the requested signedness.
  always_comb begin
    w_a_ext = i_signed_mode ? {{2{i_a[W-1]}}, i_a} : {2'b00, i_a};
    w_b_ext = i_signed_mode ? {{2{i_b[W-1]}}, i_b} : {2'b00, i_b};
  end

  // One Booth step: add the digit's addend, then shift {ACC,Q,q-1} right by two.
  always_comb begin
    w_sum     = r_acc + w_addend;
    w_shift   = $signed({w_sum, r_q, r_qm1}) >>> 2;
    w_acc_nxt = w_shift[2*W+6:W+3];
    w_q_nxt   = w_shift[W+2:1];
    w_qm1_nxt = w_shift[0];
    w_prod    = {w_acc_nxt[W-3:0], w_q_nxt};
  end

  // Next-state logic: accept START only in IDLE, return after the final iteration.
  always_comb begin
    w_state_nxt = r_state;
    w_last      = (r_cnt == CNT_W'(ITER - 1));
    case (r_state)
      IDLE:    if (i_start) w_state_nxt = CALC;
      CALC:    if (w_last)  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register, operand/accumulator datapath and registered result.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_m      <= '0;
      r_q      <= '0;
      r_qm1    <= 1'b0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
`ifdef BOOTH_MAC_EN
      r_accum  <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_done  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_m   <= w_a_ext;
            r_q   <= w_b_ext;
            r_qm1 <= 1'b0;
            r_acc <= '0;
            r_cnt <= '0;
`ifdef BOOTH_MAC_EN
            r_accum <= i_accum;
`endif
          end
        end
        CALC: begin
          r_acc <= w_acc_nxt;
          r_q   <= w_q_nxt;
          r_qm1 <= w_qm1_nxt;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_done <= 1'b1;
`ifdef BOOTH_MAC_EN
            r_result <= r_accum ? (r_result + w_prod) : w_prod;
`else
            r_result <= w_prod;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  // Output mapping.
  always_comb begin
    o_result = r_result;
    o_busy   = (r_state == CALC);
    o_done   = r_done;
  end

endmodule

// File: doc/booth_radix4_multiply.md
Name: booth_radix4_multiply

Overview:
Parametrised sequential radix-4 Booth multiplier. It is the successor to the radix-2 Booth multiply block, and retires two multiplier bits per cycle. It also adds runtime signed/unsigned selection, a busy/done handshake with a single-cycle DONE pulse, and an optional multiply-accumulate mode. It sits on the datapath as a multi-cycle arithmetic unit driven by a controller through START/DONE.

Parameters:
DATAWIDTH, 32, operand width W; must be even and >= 4 (elaboration error otherwise)
ITER, DATAWIDTH/2+1, derived localparam, number of radix-4 iterations; not overridable

Ports:
CLK  input  1  clock; one clock domain, all logic on posedge CLK
RST  input  1  reset, synchronous, active-high
START  input  1  request; sampled only in IDLE
SIGNED_MODE  input  1  1 = two's-complement operands, 0 = unsigned; sampled with START
A  input  W  multiplicand; sampled with START
B  input  W  multiplier; sampled with START
RESULT  output  2W  registered product; held until the next completion
BUSY  output  1  high while computing
DONE  output  1  one-cycle pulse when RESULT updates

Behaviour:
- Reset: CLK with RST=1 forces state IDLE, RESULT=0, BUSY=0, DONE=0, and clears internal registers. This applies at any time, including mid-operation; the aborted operation produces no DONE.
- States: IDLE, CALC. No other states.
- IDLE with START=1 (edge 0):
  - Latch M = A extended to W+2 bits (sign-extended if SIGNED_MODE, else zero-extended).
  - Latch Q = B extended to W+2 bits by the same rule, with q(-1)=0.
  - Clear ACC (W+4 bits signed) and iteration counter; go to CALC.
- IDLE with START=0: stay in IDLE.
- CALC, one iteration per clock:
  - Booth digit from {Q[1],Q[0],q(-1)}: 000/111 -> 0; 001/010 -> +M; 011 -> +2M; 100 -> -2M; 101/110 -> -M.
  - ACC += digit (sign-extended); then {ACC,Q,q(-1)} arithmetic shift right by 2. Both happen in the same cycle.
- Completion: on the edge ending iteration ITER:
  - RESULT <= low 2W bits of the final {ACC,Q} product alignment.
  - DONE <= 1 for exactly one cycle; BUSY <= 0; state <= IDLE.
- Latency: DONE is high in the cycle immediately after the ITER-th CALC edge, i.e. ITER cycles after the START edge (17 for W=32, 5 for W=8).
- BUSY = (state==CALC); high from the cycle after the START edge through the last CALC cycle.
- START while BUSY: ignored; no queueing and no error.
- START in the DONE cycle: accepted, since state is already IDLE; back-to-back throughput is one result per ITER+1 cycles.
- A, B and SIGNED_MODE may change freely during CALC without effect.
- Arithmetic: the product is exact for all inputs in both modes, including signed min*min and unsigned max*max; no overflow is possible.
- RESULT is stable except on the completion edge or reset.

Optional Feature:
- Macro BOOTH_MAC_EN.
- Defined:
  - Adds input port ACCUM (1 bit), sampled with START.
  - If ACCUM=1, the completion edge writes RESULT <= RESULT + product (mod 2^2W, no saturation, no flag). The old RESULT is read at completion.
  - If ACCUM=0, behaviour is identical to the undefined case.
- Undefined: ACCUM port absent; RESULT <= product.
- Latency is unchanged in both cases.

Decomposition:
- Package booth_pkg:
  - State enum (IDLE, CALC).
  - Booth digit enum (ZERO, POS1, POS2, NEG1, NEG2).
  - Function booth_iter(W) returning W/2+1.
  - Function for the ACC width (W+4).
- One natural sub-module: booth_r4_encoder. Combinational; maps the 3-bit window to a digit, and the digit plus M to the sign-extended addend. It is instantiated once.

Test Plan:
1. W=8, signed, A=0x80, B=0x80 -> RESULT=0x4000; DONE pulse exactly 5 cycles after the START edge; BUSY high for 5 cycles.
2. W=8, unsigned, A=0xFF, B=0xFF -> RESULT=0xFE01. Signed, same operands -> RESULT=0x0001. Unsigned, A=0xFF, B=0x01 -> 0x00FF. Signed, A=0xFF, B=0x01 -> 0xFFFF.
3. W=8, START at cycle 0 (A=3, B=5), then START pulses with A=7, B=7 during BUSY -> single DONE, RESULT=15; second START in the DONE cycle (A=7, B=7) -> RESULT=49 after 5 more cycles.
4. W=8, RST asserted 2 cycles into CALC -> next cycle RESULT=0, BUSY=0, DONE=0, and no DONE ever follows; a subsequent START of 2*3 -> 6.
5. W=32, 10k random signed/unsigned operand pairs vs a reference model -> exact 64-bit match, DONE 17 cycles after each START edge.
6. BOOTH_MAC_EN, W=8, unsigned: 10*10 with ACCUM=0 -> 100; then 5*4 with ACCUM=1 -> 120; then 0xFF*0xFF with ACCUM=1 -> (120+65025) mod 65536 = 0xFE79.
